// File: rtl/enkoder64_if.sv
// enkoder64 host-side bundle: control, plaintext/key in, ciphertext and status out.
// The master modport is the host; the slave modport is the encryptor.
interface enkoder64_if #(
    parameter int N = 64,
    parameter int K = 128
);
    logic         ena;
    logic         start;
    logic [N-1:0] data;
    logic [K-1:0] key;
    logic [N-1:0] res;
    logic         rdy;
    logic         busy;

    modport master (
        output ena, start, data, key,
        input  res, rdy, busy
    );

    modport slave (
        input  ena, start, data, key,
        output res, rdy, busy
    );
endinterface

// File: rtl/enkoder64.sv
// enkoder64: TEA block encryptor, one Feistel half-round per cycle.
// Optional macro ENKODER64_B2B_EN: accept a new block in the STORE cycle.
module enkoder64 #(
    parameter int          N      = 64,
    parameter int          K      = 128,
    parameter logic [31:0] DELTA  = 32'h9E3779B9,
    parameter int          ROUNDS = 32
) (
    input  logic        clk,
    input  logic        rst,
    enkoder64_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        HALF_L,
        HALF_R,
        STORE
    } state_t;

    state_t       state, state_n;
    logic [31:0]  l_q, l_n;
    logic [31:0]  r_q, r_n;
    logic [31:0]  sum_q, sum_n;
    logic [4:0]   rnd_q, rnd_n;
    logic [31:0]  k0_q, k0_n;
    logic [31:0]  k1_q, k1_n;
    logic [31:0]  k2_q, k2_n;
    logic [31:0]  k3_q, k3_n;
    logic [N-1:0] res_q, res_n;
    logic         rdy_q, rdy_n;
    logic         accept;
    logic [31:0]  f_l;
    logic [31:0]  f_r;

    function automatic logic [31:0] f_mix(
        input logic [31:0] x,
        input logic [31:0] s,
        input logic [31:0] a,
        input logic [31:0] b
    );
        f_mix = ((x << 4) + a) ^ (x + s) ^ ((x >> 5) + b);
    endfunction

    // HALF_R mixes the L written by the preceding HALF_L
    assign f_l = f_mix(r_q, sum_q, k0_q, k1_q);
    assign f_r = f_mix(l_q, sum_q, k2_q, k3_q);

    always_comb begin
        accept = 1'b0;
        unique case (state)
            IDLE:    accept = bus.start;
`ifdef ENKODER64_B2B_EN
            STORE:   accept = bus.start;
`endif
            default: accept = 1'b0;
        endcase
    end

    always_comb begin
        state_n = state;
        l_n     = l_q;
        r_n     = r_q;
        sum_n   = sum_q;
        rnd_n   = rnd_q;
        k0_n    = k0_q;
        k1_n    = k1_q;
        k2_n    = k2_q;
        k3_n    = k3_q;
        res_n   = res_q;
        rdy_n   = 1'b0;
        unique case (state)
            IDLE: begin
            end
            HALF_L: begin
                l_n     = l_q + f_l;
                state_n = HALF_R;
            end
            HALF_R: begin
                r_n     = r_q + f_r;
                sum_n   = sum_q + DELTA;
                rnd_n   = rnd_q + 5'd1;
                if (rnd_q == 5'(ROUNDS - 1))
                    state_n = STORE;
                else
                    state_n = HALF_L;
            end
            STORE: begin
                res_n   = {l_q, r_q};
                rdy_n   = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (accept) begin
            l_n     = bus.data[N-1:32];
            r_n     = bus.data[31:0];
            k0_n    = bus.key[K-1:96];
            k1_n    = bus.key[95:64];
            k2_n    = bus.key[63:32];
            k3_n    = bus.key[31:0];
            sum_n   = DELTA;
            rnd_n   = 5'd0;
            state_n = HALF_L;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            l_q   <= '0;
            r_q   <= '0;
            sum_q <= '0;
            rnd_q <= '0;
            k0_q  <= '0;
            k1_q  <= '0;
            k2_q  <= '0;
            k3_q  <= '0;
            res_q <= '0;
            rdy_q <= 1'b0;
        end else if (bus.ena) begin
            state <= state_n;
            l_q   <= l_n;
            r_q   <= r_n;
            sum_q <= sum_n;
            rnd_q <= rnd_n;
            k0_q  <= k0_n;
            k1_q  <= k1_n;
            k2_q  <= k2_n;
            k3_q  <= k3_n;
            res_q <= res_n;
            rdy_q <= rdy_n;
        end
    end

    assign bus.res  = res_q;
    assign bus.rdy  = rdy_q;
    assign bus.busy = (state != IDLE);

endmodule

// File: tb/tb_enkoder64.sv
// tb_enkoder64: directed tests against a transaction-level TEA model.
// Model tracks enabled edges since accept; outputs are checked every cycle.
module tb_enkoder64;

    localparam logic [31:0] DELTA = 32'h9E3779B9;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;
    logic chk_on = 1'b0;

    enkoder64_if bif ();

    enkoder64 dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] tea_enc(input logic [63:0] d, input logic [127:0] k);
        logic [31:0] v0, v1, s;
        v0 = d[63:32];
        v1 = d[31:0];
        s  = 32'd0;
        for (int i = 0; i < 32; i++) begin
            s  = s + DELTA;
            v0 = v0 + (((v1 << 4) + k[127:96]) ^ (v1 + s) ^ ((v1 >> 5) + k[95:64]));
            v1 = v1 + (((v0 << 4) + k[63:32]) ^ (v0 + s) ^ ((v0 >> 5) + k[31:0]));
        end
        return {v0, v1};
    endfunction

    function automatic logic [63:0] tea_dec(input logic [63:0] d, input logic [127:0] k);
        logic [31:0] v0, v1, s;
        v0 = d[63:32];
        v1 = d[31:0];
        s  = DELTA * 32'd32;
        for (int i = 0; i < 32; i++) begin
            v1 = v1 - (((v0 << 4) + k[63:32]) ^ (v0 + s) ^ ((v0 >> 5) + k[31:0]));
            v0 = v0 - (((v1 << 4) + k[127:96]) ^ (v1 + s) ^ ((v1 >> 5) + k[95:64]));
            s  = s - DELTA;
        end
        return {v0, v1};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: edges-since-accept counter, result computed in one shot
    int          m_cnt;
    logic [63:0] m_res;
    logic [63:0] m_pend;
    logic        m_rdy;

    always @(posedge clk) begin
        int was;
        logic can_acc;
        if (!rst) begin
            m_cnt = 0;
            m_res = '0;
            m_rdy = 1'b0;
        end else if (bif.ena) begin
            was   = m_cnt;
            m_rdy = 1'b0;
            if (was == 65) begin
                m_res = m_pend;
                m_rdy = 1'b1;
                m_cnt = 0;
            end else if (was > 0) begin
                m_cnt = was + 1;
            end
`ifdef ENKODER64_B2B_EN
            can_acc = (was == 0) || (was == 65);
`else
            can_acc = (was == 0);
`endif
            if (bif.start && can_acc) begin
                m_pend = tea_enc(bif.data, bif.key);
                m_cnt  = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("rdy", 64'(bif.rdy), 64'(m_rdy));
            chk("busy", 64'(bif.busy), 64'(m_cnt != 0));
            chk("res", bif.res, m_res);
        end
    end

    // Pulse start for one cycle; returns at the negedge after the accept edge
    task automatic kick(input logic [63:0] d, input logic [127:0] k);
        bif.data  = d;
        bif.key   = k;
        bif.start = 1'b1;
        @(negedge clk);
        bif.start = 1'b0;
    endtask

    task automatic wait_rdy(output int k);
        k = 0;
        while (!bif.rdy && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (!bif.rdy) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_rdy: no rdy within %0d cycles", k);
        end
    endtask

    task automatic count_rdy(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bif.rdy) pulses++;
        end
    endtask

    localparam logic [127:0] KEY_A = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [63:0]  DAT_A = 64'hDEADBEEF_CAFEBABE;

    initial begin
        int k;
        int p;
        logic [63:0] c_a;
        rst       = 1'b0;
        bif.ena   = 1'b1;
        bif.start = 1'b0;
        bif.data  = '0;
        bif.key   = '0;
        repeat (2) @(negedge clk);
        chk_on = 1'b1;
        chk("reset_res", bif.res, 64'h0);
        chk("reset_busy", 64'(bif.busy), 64'h0);
        rst = 1'b1;
        @(negedge clk);

        // Zero vector
        chk("model_zero", tea_enc(64'h0, 128'h0), 64'h41EA3A0A94BAA940);
        kick(64'h0, 128'h0);
        wait_rdy(k);
        chk("zero_latency", 64'(k), 64'd65);
        chk("zero_res", bif.res, 64'h41EA3A0A94BAA940);
        @(negedge clk);
        chk("zero_rdy_low", 64'(bif.rdy), 64'h0);
        chk("zero_res_hold", bif.res, 64'h41EA3A0A94BAA940);

        // Round trip
        c_a = tea_enc(DAT_A, KEY_A);
        chk("model_roundtrip", tea_dec(c_a, KEY_A), DAT_A);
        kick(DAT_A, KEY_A);
        wait_rdy(k);
        chk("rt_latency", 64'(k), 64'd65);
        chk("rt_res", bif.res, c_a);
        chk("rt_decrypt", tea_dec(bif.res, KEY_A), DAT_A);
        @(negedge clk);

        // Reset mid-run
        kick(64'h0011223344556677, KEY_A);
        repeat (29) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("mid_rst_res", bif.res, 64'h0);
        chk("mid_rst_rdy", 64'(bif.rdy), 64'h0);
        chk("mid_rst_busy", 64'(bif.busy), 64'h0);
        kick(64'h0123456789ABCDEF, 128'h1);
        wait_rdy(k);
        chk("post_rst_latency", 64'(k), 64'd65);
        chk("post_rst_res", bif.res, tea_enc(64'h0123456789ABCDEF, 128'h1));
        @(negedge clk);

        // Enable stall mid-run and during rdy
        kick(DAT_A, ~KEY_A);
        repeat (19) @(negedge clk);
        bif.ena = 1'b0;
        repeat (10) @(negedge clk);
        bif.ena = 1'b1;
        k = 29;
        while (!bif.rdy && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("stall_latency", 64'(k), 64'd75);
        bif.ena = 1'b0;
        p = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bif.rdy) p++;
        end
        bif.ena = 1'b1;
        chk("stall_rdy_len", 64'(p), 64'd4);
        chk("stall_res", bif.res, tea_enc(DAT_A, ~KEY_A));
        @(negedge clk);
        chk("stall_rdy_end", 64'(bif.rdy), 64'h0);

        // Start ignored while busy
        kick(64'hA5A5A5A55A5A5A5A, KEY_A);
        repeat (19) @(negedge clk);
        bif.data  = 64'hFFFFFFFF00000000;
        bif.start = 1'b1;
        @(negedge clk);
        bif.start = 1'b0;
        count_rdy(150, p);
        chk("busy_ign_pulses", 64'(p), 64'd1);
        chk("busy_ign_res", bif.res, tea_enc(64'hA5A5A5A55A5A5A5A, KEY_A));

        // Start in the STORE cycle
        kick(64'h1111111122222222, KEY_A);
        repeat (64) @(negedge clk);
        bif.data  = 64'h3333333344444444;
        bif.key   = 128'h5;
        bif.start = 1'b1;
        @(negedge clk);
        bif.start = 1'b0;
        chk("store_rdy", 64'(bif.rdy), 64'h1);
        chk("store_res1", bif.res, tea_enc(64'h1111111122222222, KEY_A));
`ifdef ENKODER64_B2B_EN
        chk("b2b_busy", 64'(bif.busy), 64'h1);
        k = 0;
        @(negedge clk);
        k++;
        while (!bif.rdy && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("b2b_spacing", 64'(k), 64'd65);
        chk("b2b_res2", bif.res, tea_enc(64'h3333333344444444, 128'h5));
`else
        chk("nob2b_busy", 64'(bif.busy), 64'h0);
        count_rdy(100, p);
        chk("nob2b_pulses", 64'(p), 64'd0);
        chk("nob2b_res", bif.res, tea_enc(64'h1111111122222222, KEY_A));
`endif
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
